// File: rtl/mem_wb_skid_nlane_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : mem_wb_skid_nlane_pkg                                  |
// | Shared control-bit positions and state encodings for MEM/WB.     |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package mem_wb_skid_nlane_pkg;

    // Per-lane control pair is {mem2reg_sel, reg_wr}
    localparam int c_CTRL_REGWR = 0;
    localparam int c_CTRL_M2R   = 1;

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/memwb_skid_entry.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : memwb_skid_entry                                        |
// | One bundle-wide payload register with clear-over-load priority.  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module memwb_skid_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_skid_nlane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mem_wb_skid_nlane                                       |
// | N-lane MEM/WB register with 2-entry skid buffer, flush, r0 gate. |
// | Optional stall counter enabled by macro MEMWB_STALLCNT_EN.       |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module mem_wb_skid_nlane
    import mem_wb_skid_nlane_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int RW    = 5
) (
    input  logic                reloj,
    input  logic                resetMEM,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*LANES-1:0]  ctrl_WB_mem,
    input  logic [DW*LANES-1:0] DO,
    input  logic [DW*LANES-1:0] DIR,
    input  logic [RW*LANES-1:0] Y_MUX_mem,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES-1:0]    DIR_WB,
    output logic [LANES-1:0]    REG_WR,
    output logic [DW*LANES-1:0] DO_wb,
    output logic [DW*LANES-1:0] DIR_wb,
    output logic [RW*LANES-1:0] Y_MUX_wb,
    output logic [31:0]         stall_cnt
);

    localparam int c_PW = LANES * (2 + 2 * DW + RW);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [c_PW-1:0]    w_in_bundle;
    logic [c_PW-1:0]    w_main_d;
    logic [c_PW-1:0]    w_main_q;
    logic [c_PW-1:0]    w_skid_q;
    logic               w_main_load;
    logic               w_main_clear;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic [2*LANES-1:0] w_main_ctrl;

    assign out_valid   = (r_state != c_ST_EMPTY);
    assign in_ready    = (r_state != c_ST_FULL);
    // Flush discards both the offered bundle and any pending consume
    assign w_in_xfer   = in_valid & in_ready & ~flush;
    assign w_out_xfer  = out_valid & out_ready & ~flush;
    assign w_in_bundle = {ctrl_WB_mem, DO, DIR, Y_MUX_mem};

    always_comb begin
        w_state_nxt  = r_state;
        w_main_d     = w_in_bundle;
        w_main_load  = 1'b0;
        w_main_clear = flush;
        w_skid_load  = 1'b0;
        w_skid_clear = flush;
        if (flush) begin
            w_state_nxt = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_main_load = 1'b1;
                        w_state_nxt = c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = c_ST_FULL;
                    end else if (w_in_xfer && w_out_xfer) begin
                        w_main_load = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = c_ST_EMPTY;
                    end
                end
                c_ST_FULL: begin
                    if (w_out_xfer) begin
                        w_main_d     = w_skid_q;
                        w_main_load  = 1'b1;
                        w_skid_clear = 1'b1;
                        w_state_nxt  = c_ST_ONE;
                    end
                end
                default: w_state_nxt = c_ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge reloj or posedge resetMEM) begin
        if (resetMEM) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    memwb_skid_entry #(.W(c_PW)) u_main (
        .clk     (reloj),
        .rst     (resetMEM),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    memwb_skid_entry #(.W(c_PW)) u_skid (
        .clk     (reloj),
        .rst     (resetMEM),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_d     (w_in_bundle),
        .o_q     (w_skid_q)
    );

    assign {w_main_ctrl, DO_wb, DIR_wb, Y_MUX_wb} = w_main_q;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            // Writes to r0 are suppressed here so WB never needs to check
            assign REG_WR[i] = w_main_ctrl[2*i+c_CTRL_REGWR] & out_valid &
                               (Y_MUX_wb[RW*i +: RW] != '0);
            assign DIR_WB[i] = w_main_ctrl[2*i+c_CTRL_M2R];
        end
    endgenerate

`ifdef MEMWB_STALLCNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge reloj or posedge resetMEM) begin
        if (resetMEM) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid_nlane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_mem_wb_skid_nlane                                    |
// | Directed self-checking bench for mem_wb_skid_nlane.              |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_mem_wb_skid_nlane;

`ifdef MEMWB_STALLCNT_EN
    localparam int c_STALL_ON = 1;
`else
    localparam int c_STALL_ON = 0;
`endif

    logic        reloj = 1'b0;
    logic        resetMEM = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ctrl_WB_mem = '0;
    logic [63:0] DO = '0;
    logic [63:0] DIR = '0;
    logic [9:0]  Y_MUX_mem = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  DIR_WB;
    logic [1:0]  REG_WR;
    logic [63:0] DO_wb;
    logic [63:0] DIR_wb;
    logic [9:0]  Y_MUX_wb;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 reloj = ~reloj;

    mem_wb_skid_nlane dut (
        .reloj       (reloj),
        .resetMEM    (resetMEM),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ctrl_WB_mem (ctrl_WB_mem),
        .DO          (DO),
        .DIR         (DIR),
        .Y_MUX_mem   (Y_MUX_mem),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .DIR_WB      (DIR_WB),
        .REG_WR      (REG_WR),
        .DO_wb       (DO_wb),
        .DIR_wb      (DIR_wb),
        .Y_MUX_wb    (Y_MUX_wb),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic offer(input logic [31:0] d0, input logic [3:0] ctl, input logic [9:0] y);
        in_valid    = 1'b1;
        DO          = {d0 + 32'h0100_0000, d0};
        DIR         = {d0 + 32'h0200_0000, d0 + 32'h0300_0000};
        ctrl_WB_mem = ctl;
        Y_MUX_mem   = y;
    endtask

    initial begin
        // Async reset asserted between edges
        #2 resetMEM = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_reg_wr", 64'(REG_WR), 64'd0);
        check("rst_do_wb", DO_wb, 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        tick();
        tick();
        resetMEM = 1'b0;

        // Streaming
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer(32'h1000 + 32'(k), 4'b0101, {5'd2, 5'd1});
            tick();
            check("strm_valid", 64'(out_valid), 64'd1);
            check("strm_do0", 64'(DO_wb[31:0]), 64'h1000 + 64'(k));
            check("strm_in_ready", 64'(in_ready), 64'd1);
        end
        check("strm_do1", 64'(DO_wb[63:32]), 64'h0100_1003);
        check("strm_dir0", 64'(DIR_wb[31:0]), 64'h0300_1003);
        check("strm_regwr", 64'(REG_WR), 64'd3);
        in_valid = 1'b0;
        tick();
        check("strm_drain", 64'(out_valid), 64'd0);
        check("strm_regwr_idle", 64'(REG_WR), 64'd0);

        // Backpressure: A then B, held, then drained in order
        out_ready = 1'b0;
        offer(32'hA, 4'b0001, {5'd0, 5'd4});
        tick();
        check("bp_a_valid", 64'(out_valid), 64'd1);
        check("bp_a_data", 64'(DO_wb[31:0]), 64'hA);
        offer(32'hB, 4'b0001, {5'd0, 5'd5});
        tick();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_hold_a", 64'(DO_wb[31:0]), 64'hA);
        offer(32'hC, 4'b0001, {5'd0, 5'd6});
        tick();
        check("bp_hold_a2", 64'(DO_wb[31:0]), 64'hA);
        check("bp_hold_y", 64'(Y_MUX_wb), 64'd4);
        check("bp_stall2", 64'(stall_cnt), (c_STALL_ON != 0) ? 64'd2 : 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_b_valid", 64'(out_valid), 64'd1);
        check("bp_b_data", 64'(DO_wb[31:0]), 64'hB);
        check("bp_b_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);
        check("bp_stall_end", 64'(stall_cnt), (c_STALL_ON != 0) ? 64'd2 : 64'd0);

        // Flush while FULL with a bundle offered
        out_ready = 1'b0;
        offer(32'hC0, 4'b0001, {5'd0, 5'd3});
        tick();
        offer(32'hD0, 4'b0001, {5'd0, 5'd3});
        tick();
        check("fl_full", 64'(in_ready), 64'd0);
        offer(32'hE0, 4'b0001, {5'd0, 5'd3});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_regwr", 64'(REG_WR), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        check("fl_zero", DO_wb, 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_no_ghost", 64'(out_valid), 64'd0);
        check("fl_stall_kept", 64'(stall_cnt), (c_STALL_ON != 0) ? 64'd4 : 64'd0);

        // r0 write suppression
        offer(32'h55, 4'b1101, {5'd0, 5'd7});
        tick();
        check("r0_regwr", 64'(REG_WR), 64'b01);
        check("r0_dirwb", 64'(DIR_WB), 64'b10);
        offer(32'h66, 4'b1101, {5'd3, 5'd0});
        tick();
        check("r0_regwr_l0", 64'(REG_WR), 64'b10);
        check("r0_y", 64'(Y_MUX_wb), {54'd0, 5'd3, 5'd0});
        in_valid = 1'b0;
        tick();
        check("r0_idle_regwr", 64'(REG_WR), 64'd0);

        // Reset asserted while FULL loses both bundles
        out_ready = 1'b0;
        offer(32'h77, 4'b0101, {5'd1, 5'd1});
        tick();
        offer(32'h88, 4'b0101, {5'd1, 5'd1});
        tick();
        in_valid = 1'b0;
        #2 resetMEM = 1'b1;
        #1;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_ready", 64'(in_ready), 64'd1);
        check("mr_stall", 64'(stall_cnt), 64'd0);
        tick();
        resetMEM  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("mr_no_bundle", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
